// File: rtl/branch_cond_if.sv
// Decode-side request and PC-update-side result channels of the branch condition unit.
interface branch_cond_if #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned OFF_W  = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic              in_signed;
    logic [2:0]        in_nzp;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [ADDR_W-1:0] in_pc;
    logic [OFF_W-1:0]  in_offset;

    logic              out_valid;
    logic              out_ready;
    logic              out_taken;
    logic [ADDR_W-1:0] out_target;
    logic [2:0]        out_flags;

    // Producer of ops and consumer of results.
    modport master (
        output in_valid, in_op, in_signed, in_nzp, in_a, in_b, in_pc, in_offset, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_flags
    );

    // The branch condition unit itself.
    modport slave (
        input  in_valid, in_op, in_signed, in_nzp, in_a, in_b, in_pc, in_offset, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_flags
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Two-stage elastic NZP branch condition unit with persistent condition code
// and a saturating count of delivered taken branches.
module branch_cond_unit #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned OFF_W  = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    branch_cond_if.slave     bus,
    output logic [2:0]       cc,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam logic [1:0]       OP_CMP_BR = 2'b00;
    localparam logic [1:0]       OP_SETCC  = 2'b01;
    localparam logic [1:0]       OP_BRCC   = 2'b10;
    localparam logic [2:0]       CC_RESET  = 3'b010;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Stage A: captured operands.
    logic              a_valid;
    logic [1:0]        a_op;
    logic              a_signed;
    logic [2:0]        a_nzp;
    logic [WIDTH-1:0]  a_a;
    logic [WIDTH-1:0]  a_b;
    logic [ADDR_W-1:0] a_pc;
    logic [OFF_W-1:0]  a_offset;

    // Stage B: registered result presented on the output channel.
    logic              b_valid;
    logic              b_taken;
    logic [ADDR_W-1:0] b_target;
    logic [2:0]        b_flags;

    logic adv_b;
    logic adv_a;
    logic accept;
    logic out_fire;

    logic              cmp_lt;
    logic              cmp_eq;
    logic [2:0]        cmp_flags;
    logic [2:0]        dec_flags;
    logic              dec_taken;
    logic [ADDR_W-1:0] dec_target;

    // Elastic handshake: B drains when empty or consumed, A moves when B can take it.
    assign adv_b        = !b_valid || bus.out_ready;
    assign adv_a        = a_valid && adv_b;
    assign bus.in_ready = !flush && (!a_valid || adv_b);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_fire     = b_valid && bus.out_ready;

    assign bus.out_valid  = b_valid;
    assign bus.out_taken  = b_taken;
    assign bus.out_target = b_target;
    assign bus.out_flags  = b_flags;

    // Compare, select flag source by op, and test against the NZP mask.
    always_comb begin
        cmp_lt     = a_signed ? ($signed(a_a) < $signed(a_b)) : (a_a < a_b);
        cmp_eq     = (a_a == a_b);
        cmp_flags  = {cmp_lt, cmp_eq, !cmp_lt && !cmp_eq};
        dec_flags  = 3'b000;
        dec_taken  = 1'b0;
        dec_target = a_pc + ADDR_W'($signed(a_offset));
        case (a_op)
            OP_CMP_BR: begin
                dec_flags = cmp_flags;
                dec_taken = |(cmp_flags & a_nzp);
            end
            OP_SETCC: begin
                dec_flags = cmp_flags;
            end
            OP_BRCC: begin
                // BRCC reads cc as it leaves A, so an immediately preceding SETCC is visible.
                dec_flags = cc;
                dec_taken = |(cc & a_nzp);
            end
            default: begin
                dec_flags = 3'b000;
            end
        endcase
    end

    // Pipeline registers, condition code and taken counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            b_taken   <= 1'b0;
            b_target  <= '0;
            b_flags   <= 3'b000;
            cc        <= CC_RESET;
            taken_cnt <= '0;
        end else begin
            if (out_fire && b_taken && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (flush) begin
                // Kill everything in flight; a SETCC leaving A now must not touch cc.
                a_valid <= 1'b0;
                b_valid <= 1'b0;
            end else begin
                if (adv_b) begin
                    b_valid <= a_valid;
                end
                if (adv_a) begin
                    b_taken  <= dec_taken;
                    b_target <= dec_target;
                    b_flags  <= dec_flags;
                    if (a_op == OP_SETCC) begin
                        cc <= dec_flags;
                    end
                end
                if (bus.in_ready) begin
                    a_valid <= bus.in_valid;
                end
                if (accept) begin
                    a_op     <= bus.in_op;
                    a_signed <= bus.in_signed;
                    a_nzp    <= bus.in_nzp;
                    a_a      <= bus.in_a;
                    a_b      <= bus.in_b;
                    a_pc     <= bus.in_pc;
                    a_offset <= bus.in_offset;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed plus randomized checking of branch_cond_unit against a scoreboard model.
module tb_branch_cond_unit;
    localparam logic [1:0] OP_CMP = 2'd0;
    localparam logic [1:0] OP_SET = 2'd1;
    localparam logic [1:0] OP_BRC = 2'd2;
    localparam logic [1:0] OP_NOP = 2'd3;

    typedef struct {
        logic        taken;
        logic [19:0] target;
        logic [2:0]  flags;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  cc;
    logic [15:0] taken_cnt;
    logic [2:0]  cc2;
    logic [1:0]  taken_cnt2;

    branch_cond_if bus ();
    branch_cond_if bus2 ();

    branch_cond_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .cc(cc), .taken_cnt(taken_cnt)
    );

    // Second instance with a 2-bit counter sees identical traffic to exercise saturation.
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_op     = bus.in_op;
    assign bus2.in_signed = bus.in_signed;
    assign bus2.in_nzp    = bus.in_nzp;
    assign bus2.in_a      = bus.in_a;
    assign bus2.in_b      = bus.in_b;
    assign bus2.in_pc     = bus.in_pc;
    assign bus2.in_offset = bus.in_offset;
    assign bus2.out_ready = bus.out_ready;

    branch_cond_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .cc(cc2), .taken_cnt(taken_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        q[$];
    logic [2:0]  model_cc  = 3'b010;
    int          model_cnt = 0;
    logic        rdy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned values as plain integers, target as modular sum.
    function automatic exp_t model(input logic [1:0] op, input logic sg, input logic [2:0] nzp,
                                   input logic [19:0] a, input logic [19:0] b,
                                   input logic [19:0] pc, input logic [8:0] off);
        exp_t   r;
        longint va, vb, o, t;
        va = longint'(a);
        vb = longint'(b);
        if (sg && va >= (longint'(1) << 19)) va = va - (longint'(1) << 20);
        if (sg && vb >= (longint'(1) << 19)) vb = vb - (longint'(1) << 20);
        if (op == OP_BRC)      r.flags = model_cc;
        else if (op == OP_NOP) r.flags = 3'b000;
        else if (va < vb)      r.flags = 3'b100;
        else if (va == vb)     r.flags = 3'b010;
        else                   r.flags = 3'b001;
        r.taken = (op == OP_CMP || op == OP_BRC) && ((r.flags & nzp) != 3'b000);
        o = longint'(off);
        if (o >= 256) o = o - 512;
        t = longint'(pc) + o;
        if (t < 0) t = t + (longint'(1) << 20);
        if (t >= (longint'(1) << 20)) t = t - (longint'(1) << 20);
        r.target = 20'(t);
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, input logic sg, input logic [2:0] nzp,
                         input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] pc, input logic [8:0] off);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_signed = sg;
        bus.in_nzp    = nzp;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_pc     = pc;
        bus.in_offset = off;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // One clock: score handshakes seen before the edge, then check counters after it.
    task automatic tick();
        logic acc, ohs;
        exp_t e;
        #1;
        rdy_seen = bus.in_ready;
        acc = bus.in_valid && bus.in_ready && !rst;
        ohs = bus.out_valid && bus.out_ready && !rst;
        if (ohs) begin
            chk("out_has_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_taken", 32'(bus.out_taken), 32'(e.taken));
                chk("out_target", 32'(bus.out_target), 32'(e.target));
                chk("out_flags", 32'(bus.out_flags), 32'(e.flags));
                if (e.taken && model_cnt < 65535) model_cnt++;
            end
        end
        if (acc) begin
            e = model(bus.in_op, bus.in_signed, bus.in_nzp, bus.in_a, bus.in_b,
                      bus.in_pc, bus.in_offset);
            q.push_back(e);
            if (bus.in_op == OP_SET) model_cc = e.flags;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            model_cnt = 0;
            model_cc  = 3'b010;
        end else if (flush) begin
            q.delete();
        end
        chk("taken_cnt", 32'(taken_cnt), 32'(model_cnt));
        chk("taken_cnt_sat2", 32'(taken_cnt2), 32'((model_cnt > 3) ? 3 : model_cnt));
    endtask

    // Single op with explicit expected result at its out_valid cycle.
    task automatic expect_one(input string tag, input logic [1:0] op, input logic sg,
                              input logic [2:0] nzp, input logic [19:0] a, input logic [19:0] b,
                              input logic [19:0] pc, input logic [8:0] off,
                              input logic x_taken, input logic [2:0] x_flags,
                              input logic [19:0] x_target);
        drive(op, sg, nzp, a, b, pc, off);
        tick();
        idle();
        chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_taken"}, 32'(bus.out_taken), 32'(x_taken));
        chk({tag, "_flags"}, 32'(bus.out_flags), 32'(x_flags));
        chk({tag, "_target"}, 32'(bus.out_target), 32'(x_target));
        tick();
    endtask

    logic [19:0] snap_target;
    logic [2:0]  snap_flags;
    logic        snap_taken;
    logic [2:0]  cc_save;
    int          k;
    int          guard;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(OP_CMP, 1'b0, 3'b111, 20'd1, 20'd1, 20'd0, 9'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_taken", 32'(bus.out_taken), 32'd0);
        chk("rst_out_target", 32'(bus.out_target), 32'd0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
        chk("rst_cc", 32'(cc), 32'h2);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        expect_one("cmp_unsigned", OP_CMP, 1'b0, 3'b100, 20'd5, 20'd9, 20'h00100, 9'd4,
                   1'b1, 3'b100, 20'h00104);
        expect_one("cmp_signed", OP_CMP, 1'b1, 3'b100, 20'hFFFFF, 20'd1, 20'h0, 9'd0,
                   1'b1, 3'b100, 20'h0);
        expect_one("cmp_unsigned_big", OP_CMP, 1'b0, 3'b100, 20'hFFFFF, 20'd1, 20'h0, 9'd0,
                   1'b0, 3'b001, 20'h0);
        expect_one("wrap_up", OP_CMP, 1'b0, 3'b000, 20'd3, 20'd3, 20'hFFFFE, 9'd3,
                   1'b0, 3'b010, 20'h00001);
        expect_one("wrap_down", OP_CMP, 1'b0, 3'b111, 20'd3, 20'd4, 20'h00010, 9'h100,
                   1'b1, 3'b100, 20'hFFF10);
        expect_one("mask000", OP_CMP, 1'b1, 3'b000, 20'd9, 20'd2, 20'h1, 9'd0,
                   1'b0, 3'b001, 20'h1);
        expect_one("mask111", OP_CMP, 1'b1, 3'b111, 20'd9, 20'd2, 20'h1, 9'd0,
                   1'b1, 3'b001, 20'h1);
        expect_one("nop", OP_NOP, 1'b0, 3'b111, 20'd1, 20'd1, 20'h5, 9'h1FF,
                   1'b0, 3'b000, 20'h4);

        // SETCC immediately followed by BRCC, twice.
        drive(OP_SET, 1'b0, 3'b000, 20'd7, 20'd7, 20'h0, 9'd0);
        tick();
        drive(OP_BRC, 1'b0, 3'b010, 20'd0, 20'd1, 20'h0, 9'd0);
        tick();
        idle();
        chk("setcc1_taken", 32'(bus.out_taken), 32'd0);
        chk("setcc1_flags", 32'(bus.out_flags), 32'h2);
        tick();
        chk("brcc1_taken", 32'(bus.out_taken), 32'd1);
        chk("brcc1_cc", 32'(cc), 32'h2);
        tick();
        drive(OP_SET, 1'b0, 3'b000, 20'd8, 20'd7, 20'h0, 9'd0);
        tick();
        drive(OP_BRC, 1'b0, 3'b010, 20'd0, 20'd0, 20'h0, 9'd0);
        tick();
        idle();
        tick();
        chk("brcc2_taken", 32'(bus.out_taken), 32'd0);
        chk("brcc2_flags", 32'(bus.out_flags), 32'h1);
        chk("brcc2_cc", 32'(cc), 32'h1);
        tick();

        // Backpressure: four ops streamed against a stalled consumer.
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            drive(OP_CMP, 1'b0, 3'b110, 20'(k + 1), 20'd2, 20'(16 * (k + 1)), 9'd1);
            tick();
            if (rdy_seen) k++;
            if (c == 1) begin
                snap_taken  = bus.out_taken;
                snap_target = bus.out_target;
                snap_flags  = bus.out_flags;
            end
        end
        chk("bp_in_ready_drop", 32'(rdy_seen), 32'd0);
        chk("bp_accepted", 32'(k), 32'd2);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_taken", 32'(bus.out_taken), 32'(snap_taken));
        chk("bp_hold_target", 32'(bus.out_target), 32'(snap_target));
        chk("bp_hold_flags", 32'(bus.out_flags), 32'(snap_flags));
        bus.out_ready = 1'b1;
        guard = 0;
        while (k < 4 && guard < 20) begin
            drive(OP_CMP, 1'b0, 3'b110, 20'(k + 1), 20'd2, 20'(16 * (k + 1)), 9'd1);
            tick();
            if (rdy_seen) k++;
            guard++;
        end
        chk("bp_all_accepted", 32'(k), 32'd4);
        idle();
        for (int c = 0; c < 4; c++) tick();
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Flush with both stages full and a SETCC sitting in A.
        cc_save = model_cc;
        bus.out_ready = 1'b0;
        drive(OP_CMP, 1'b0, 3'b111, 20'd1, 20'd1, 20'h0, 9'd0);
        tick();
        drive(OP_SET, 1'b0, 3'b000, 20'd3, 20'd3, 20'h0, 9'd0);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready", 32'(rdy_seen), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        model_cc = cc_save;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_output", 32'(bus.out_valid), 32'd0);
        chk("flush_cc_kept", 32'(cc), 32'(cc_save));

        // Flush while a SETCC would move A->B into an empty B.
        drive(OP_SET, 1'b0, 3'b000, 20'd2, 20'd5, 20'h0, 9'd0);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_cc = cc_save;
        tick();
        chk("flush_setcc_cc", 32'(cc), 32'(cc_save));
        chk("flush_setcc_out", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a stream of taken branches.
        for (int c = 0; c < 4; c++) begin
            drive(OP_CMP, 1'b0, 3'b111, 20'(c), 20'd0, 20'h0, 9'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("mid_rst_cc", 32'(cc), 32'h2);
        chk("mid_rst_cnt", 32'(taken_cnt), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        chk("mid_rst_dropped", 32'(bus.out_valid), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [19:0] ra;
                ra = 20'($urandom);
                drive(2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), ra,
                      ($urandom_range(0, 2) == 0) ? ra : 20'($urandom),
                      20'($urandom), 9'($urandom));
            end else begin
                idle();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rand_cc", 32'(cc), 32'(model_cc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
